// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED codec: status codes, the
// width derivations and the payload-bit to codeword-position mapping.
package hamming_pkg;

  localparam logic [1:0] STATUS_CLEAN  = 2'b00;
  localparam logic [1:0] STATUS_CORR   = 2'b01;
  localparam logic [1:0] STATUS_UNCORR = 2'b10;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_par_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Hamming positions 1..N plus the overall parity bit at index 0.
  function automatic int calc_code_w(input int data_w);
    return data_w + calc_par_w(data_w) + 1;
  endfunction

  // Codeword position of payload bit idx: payload fills the
  // non-power-of-two positions in ascending order, LSB first.
  function automatic int data_pos(input int idx);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 1; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx && pos == 0) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Purely combinational SECDED datapath: encodes a payload or decodes,
// classifies and (where possible) corrects a received codeword.
module hamming_secded_core
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = calc_code_w(DATA_W)
) (
  input  logic              mode,
  input  logic [CODE_W-1:0] code_in,
  output logic [CODE_W-1:0] result,
  output logic [1:0]        status,
  output logic [PAR_W-1:0]  syndrome
);

  logic [CODE_W-1:0] enc;
  logic [CODE_W-1:0] fixed;
  logic [PAR_W-1:0]  syn;
  logic              par_all;
  logic [1:0]        dec_status;
  logic [DATA_W-1:0] payload;

  // Encoder: scatter payload, then fill each power-of-two parity position.
  always_comb begin
    // NOTE: every variable gets a default before any branch or loop so no
    // path can leave it unassigned, which would infer a latch.
    enc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      enc[data_pos(i)] = code_in[i];
    end
    for (int k = 0; k < PAR_W; k++) begin
      for (int pos = 1; pos < CODE_W; pos++) begin
        if ((((pos >> k) & 1) != 0) && (pos != (1 << k))) begin
          enc[1 << k] = enc[1 << k] ^ enc[pos];
        end
      end
    end
    enc[0] = ^enc[CODE_W-1:1];
  end

  // Decoder: syndrome and overall parity, then classify and correct.
  always_comb begin
    syn = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (code_in[pos]) syn = syn ^ PAR_W'(pos);
    end
    par_all    = ^code_in;
    fixed      = code_in;
    dec_status = STATUS_CLEAN;
    if (par_all) begin
      // An odd error count pointing inside the word is a single-bit error;
      // syndrome 0 means the overall parity bit itself flipped.
      if (int'(syn) < CODE_W) begin
        dec_status = STATUS_CORR;
        for (int pos = 0; pos < CODE_W; pos++) begin
          if (PAR_W'(pos) == syn) fixed[pos] = ~fixed[pos];
        end
      end else begin
        dec_status = STATUS_UNCORR;
      end
    end else if (syn != '0) begin
      dec_status = STATUS_UNCORR;
    end
    payload = '0;
    for (int i = 0; i < DATA_W; i++) begin
      payload[i] = fixed[data_pos(i)];
    end
  end

  // Result select: encode beats report clean status and zero syndrome.
  always_comb begin
    result   = enc;
    status   = STATUS_CLEAN;
    syndrome = '0;
    if (mode) begin
      result   = CODE_W'(payload);
      status   = dec_status;
      syndrome = syn;
    end
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// Hamming SECDED encoder/decoder with a single valid/ready output register
// stage and saturating counters of corrected and uncorrectable results.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = calc_code_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic [CODE_W-1:0] core_data;
  logic [1:0]        core_status;
  logic [PAR_W-1:0]  core_syndrome;
  logic              accept;

  hamming_secded_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .mode     (in_mode),
    .code_in  (in_data),
    .result   (core_data),
    .status   (core_status),
    .syndrome (core_syndrome)
  );

  // The register may refill in the same cycle it drains, so a stream runs
  // without bubbles.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drop valid once drained, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath fields are reset as well because they must read
      // zero while reset is held; a plain data pipeline would skip this.
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_status   <= STATUS_CLEAN;
      out_syndrome <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples the values
      // that existed before the edge, independent of statement order.
      out_valid    <= 1'b1;
      out_data     <= core_data;
      out_status   <= core_status;
      out_syndrome <= core_syndrome;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Saturating error counters; a clear in the same cycle beats an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (accept) begin
      if (core_status == STATUS_CORR && cnt_corr != '1) begin
        cnt_corr <= cnt_corr + CNT_W'(1);
      end
      if (core_status == STATUS_UNCORR && cnt_uncorr != '1) begin
        cnt_uncorr <= cnt_uncorr + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hamming_secded_codec.md
HAMMING_SECDED_CODEC -- requirements
Module: hamming_secded_codec

Interface
REQ-001 DATA_W, default 8, payload width; legal range 4..16.
REQ-002 PAR_W, derived, not overridable: smallest p with 2^p >= DATA_W+p+1 (4 for DATA_W=8).
REQ-003 CODE_W, derived: DATA_W+PAR_W+1 (13 for DATA_W=8).
REQ-004 CNT_W, default 8, error counter width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  input beat present.
REQ-009 in_ready  out  1  block accepts beat.
REQ-010 in_mode  in  1  0=encode, 1=decode.
REQ-011 in_data  in  CODE_W  encode: payload in [DATA_W-1:0], upper bits ignored; decode: full codeword.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out_data  out  CODE_W  encode: codeword; decode: corrected payload in [DATA_W-1:0], upper bits 0.
REQ-015 out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 unused; always 00 for encode beats.
REQ-016 out_syndrome  out  PAR_W  Hamming syndrome of decode beat; 0 for encode beats.
REQ-017 cnt_clr  in  1  synchronous clear of both counters.
REQ-018 cnt_corr, cnt_uncorr  out  CNT_W each  saturating counts of status 01 and 10 results.

Function
REQ-019 Codeword bit i holds Hamming position i for i=1..CODE_W-1; parity bits at power-of-two positions; payload bits LSB-first into remaining positions ascending; bit 0 = overall even parity over bits CODE_W-1..1.
REQ-020 Parity bit at position 2^k SHALL be the XOR of all positions >=1 whose index has bit k set.
REQ-021 Decode: syndrome s = XOR of indices of set bits in positions 1..CODE_W-1; overall p = XOR of all CODE_W bits.
REQ-022 s=0, p=0: status 00, payload extracted unchanged.
REQ-023 p=1 and s<CODE_W: flip bit s (s=0 flips bit 0), status 01.
REQ-024 p=1 and s>=CODE_W: status 10, payload uncorrected.
REQ-025 s!=0, p=0: status 10, payload uncorrected.
REQ-026 Single output register stage; latency exactly 1 cycle from accepted input to out_valid.
REQ-027 in_ready = !out_valid || out_ready (combinational); a beat transfers when in_valid && in_ready.
REQ-028 out_data/out_status/out_syndrome SHALL hold stable while out_valid && !out_ready.
REQ-029 Accept and drain in same cycle SHALL yield back-to-back results with no bubble.
REQ-030 Counters increment on the cycle a result is loaded into the output register, saturate at all-ones.
REQ-031 cnt_clr asserted with an increment: clear wins, counter = 0.
REQ-032 Mode is per beat; interleaved encode/decode beats SHALL need no idle cycles.

Reset
REQ-033 rst_n low: out_valid=0, out_data=0, out_status=00, out_syndrome=0, cnt_corr=0, cnt_uncorr=0, immediately and independent of clk.
REQ-034 Reset mid-transfer discards the held result; in_ready=1 from the first cycle after release.

Structure
REQ-035 Package hamming_pkg: status encoding constants, PAR_W/CODE_W derivation functions, bit-position mapping function.
REQ-036 Combinational sub-module hamming_secded_core (encode, syndrome, correct); top holds pipeline register, handshake and counters.

Verification (DATA_W=8)
REQ-037 Encode 0xA5 -> out_data 0x144E, status 00, one cycle later.
REQ-038 Decode 0x140E (bit 6 flipped) -> out_data 0x0A5, status 01, syndrome 6, cnt_corr 1.
REQ-039 Decode 0x1406 (bits 6, 3 flipped) -> status 10, syndrome 5, cnt_uncorr 1; decode 0x144F -> 0x0A5, status 01, syndrome 0.
REQ-040 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output held; release -> stream resumes, no beat lost or duplicated.
REQ-041 CNT_W=2, 5 corrected beats -> cnt_corr 3; cnt_clr on a corrected beat -> 0.
REQ-042 rst_n pulsed low while out_valid=1, out_ready=0 -> out_valid 0 asynchronously, counters 0.
